// File: rtl/plru_pkg.sv
// rtl/plru_pkg.sv - shared constants and helpers for the PLRU allocation slice
package plru_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = 16;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    function automatic logic [31:0] onehot(input int idx);
        onehot = 32'd1 << idx;
    endfunction

    function automatic int popcount(input logic [31:0] v);
        popcount = 0;
        for (int i = 0; i < 32; i++) begin
            popcount += int'(v[i]);
        end
    endfunction

endpackage

// File: rtl/plru_lru_pick.sv
// rtl/plru_lru_pick.sv - masked least-recent search over a pairwise recency matrix
module plru_lru_pick import plru_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH*WIDTH-1:0] vv_matrix,
    input  logic [WIDTH-1:0]       cand_mask,
    output logic [IDX_W-1:0]       pick_idx,
    output logic                   pick_found
);

    logic [WIDTH-1:0] is_min;

    // A candidate is least recent when its row is zero over all other candidates.
    always_comb begin
        is_min = cand_mask;
        for (int v = 0; v < WIDTH; v++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (j != v && cand_mask[j] && vv_matrix[v*WIDTH+j]) begin
                    is_min[v] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        pick_idx   = '0;
        pick_found = |cand_mask;
        for (int v = WIDTH - 1; v >= 0; v--) begin
            if (cand_mask[v]) begin
                pick_idx = IDX_W'(v);
            end
        end
        for (int v = WIDTH - 1; v >= 0; v--) begin
            if (is_min[v]) begin
                pick_idx = IDX_W'(v);
            end
        end
    end

endmodule

// File: rtl/tree_plru.sv
// rtl/tree_plru.sv - tree pseudo-LRU state exported as a pairwise recency matrix
module tree_plru import plru_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alloc_en,
    input  logic [WIDTH-1:0]       v_alloc,
    output logic [WIDTH*WIDTH-1:0] vv_matrix
);

    // Heap-numbered nodes 1..WIDTH-1; node bit 1 means the right subtree was used last.
    logic [WIDTH-2:0] node_vec;

    function automatic int lca_node(input int a, input int b);
        int x;
        int y;
        x = WIDTH + a;
        y = WIDTH + b;
        while (x != y) begin
            x = x >> 1;
            y = y >> 1;
        end
        return x;
    endfunction

    function automatic int side_of(input int a, input int node);
        int x;
        x = WIDTH + a;
        while ((x >> 1) != node) begin
            x = x >> 1;
        end
        return x & 1;
    endfunction

    for (genvar n = 1; n < WIDTH; n++) begin : g_node
        logic touch;
        logic side;
        logic bit_q;

        always_comb begin
            touch = 1'b0;
            side  = 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                for (int l = 0; l < IDX_W; l++) begin
                    if (v_alloc[i] && (((WIDTH + i) >> (l + 1)) == n)) begin
                        touch = 1'b1;
                        side  = 1'(((WIDTH + i) >> l) & 1);
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                bit_q <= 1'b0;
            end else if (alloc_en && touch) begin
                bit_q <= side;
            end
        end

        assign node_vec[n-1] = bit_q;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_row
        for (genvar j = 0; j < WIDTH; j++) begin : g_col
            if (i == j) begin : g_diag
                assign vv_matrix[i*WIDTH+j] = 1'b0;
            end else begin : g_pair
                localparam int   NODE = lca_node(i, j);
                localparam logic SIDE = 1'(side_of(i, NODE));
                assign vv_matrix[i*WIDTH+j] = (node_vec[NODE-1] == SIDE);
            end
        end
    end

endmodule

// File: rtl/plru_victim_alloc.sv
// rtl/plru_victim_alloc.sv - allocation front-end choosing free or LRU victim entries
module plru_victim_alloc import plru_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   hit_valid,
    input  logic [IDX_W-1:0]       hit_idx,
    input  logic                   inv_valid,
    input  logic [IDX_W-1:0]       inv_idx,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       lock_mask,
    input  logic [WIDTH*WIDTH-1:0] vv_matrix,
    output logic                   alloc_en,
    output logic [WIDTH-1:0]       v_alloc,
    output logic                   gnt_valid,
    output logic [IDX_W-1:0]       gnt_idx,
    output logic                   gnt_evict,
    output logic [WIDTH-1:0]       valid_vec,
    output logic [IDX_W:0]         occupancy,
    output logic [CNT_W-1:0]       evict_cnt
);

    logic [0:0]       state;
    logic             any_free;
    logic             pick_found;
    logic             candidate_exists;
    logic             accept;
    logic             hit_act;
    logic             sel_evict;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] sel;
    logic [WIDTH-1:0] valid_next;

    assign any_free = ~&valid_vec;

    always_comb begin
        free_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    plru_lru_pick #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_pick (
        .vv_matrix  (vv_matrix),
        .cand_mask  (~lock_mask),
        .pick_idx   (pick_idx),
        .pick_found (pick_found)
    );

    // Free entries are always preferred and bypass the lock mask.
    assign candidate_exists = any_free | pick_found;
    assign sel              = any_free ? free_idx : pick_idx;
    assign sel_evict        = valid_vec[sel];
    assign req_ready        = (state == ST_IDLE) && !flush && !hit_valid && candidate_exists;
    assign accept           = req_valid && req_ready;
    assign hit_act          = hit_valid && (state == ST_IDLE);

    always_comb begin
        alloc_en = 1'b0;
        v_alloc  = '0;
        if (hit_act) begin
            alloc_en = 1'b1;
            v_alloc  = WIDTH'(onehot(int'(hit_idx)));
        end else if (accept) begin
            alloc_en = 1'b1;
            v_alloc  = WIDTH'(onehot(int'(sel)));
        end
    end

    always_comb begin
        valid_next = valid_vec;
        if (flush) begin
            valid_next = '0;
        end else begin
            if (inv_valid) begin
                valid_next[inv_idx] = 1'b0;
            end
            if (accept) begin
                valid_next[sel] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            valid_vec <= '0;
            occupancy <= '0;
            evict_cnt <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            gnt_evict <= 1'b0;
        end else begin
            state     <= flush ? ST_FLUSH : ST_IDLE;
            valid_vec <= valid_next;
            occupancy <= (IDX_W+1)'(popcount(32'(valid_next)));
            gnt_valid <= accept;
            gnt_evict <= accept && sel_evict;
            if (accept) begin
                gnt_idx <= sel;
            end
            if (accept && sel_evict && !(&evict_cnt)) begin
                evict_cnt <= evict_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_plru_victim_alloc.sv
// tb/tb_plru_victim_alloc.sv - directed closed-loop bench for plru_victim_alloc with tree_plru
module tb_plru_victim_alloc;

    localparam int WIDTH = 4;
    localparam int IDX_W = 2;
    localparam int CNT_W = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   req_valid;
    logic                   req_ready;
    logic                   hit_valid;
    logic [IDX_W-1:0]       hit_idx;
    logic                   inv_valid;
    logic [IDX_W-1:0]       inv_idx;
    logic                   flush;
    logic [WIDTH-1:0]       lock_mask;
    logic [WIDTH*WIDTH-1:0] vv_matrix;
    logic                   alloc_en;
    logic [WIDTH-1:0]       v_alloc;
    logic                   gnt_valid;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   gnt_evict;
    logic [WIDTH-1:0]       valid_vec;
    logic [IDX_W:0]         occupancy;
    logic [CNT_W-1:0]       evict_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    plru_victim_alloc #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .hit_valid (hit_valid),
        .hit_idx   (hit_idx),
        .inv_valid (inv_valid),
        .inv_idx   (inv_idx),
        .flush     (flush),
        .lock_mask (lock_mask),
        .vv_matrix (vv_matrix),
        .alloc_en  (alloc_en),
        .v_alloc   (v_alloc),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt_evict (gnt_evict),
        .valid_vec (valid_vec),
        .occupancy (occupancy),
        .evict_cnt (evict_cnt)
    );

    tree_plru #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_plru (
        .clk       (clk),
        .rst_n     (rst_n),
        .alloc_en  (alloc_en),
        .v_alloc   (v_alloc),
        .vv_matrix (vv_matrix)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic fill4();
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        req_valid = 1'b0;
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        hit_valid = 1'b0;
        hit_idx   = '0;
        inv_valid = 1'b0;
        inv_idx   = '0;
        flush     = 1'b0;
        lock_mask = '0;
        #1;
        chk("rst_valid_vec", 32'(valid_vec), 32'h0);
        chk("rst_occupancy", 32'(occupancy), 32'h0);
        chk("rst_evict_cnt", 32'(evict_cnt), 32'h0);
        chk("rst_gnt_valid", 32'(gnt_valid), 32'h0);
        chk("rst_gnt_idx", 32'(gnt_idx), 32'h0);
        chk("rst_gnt_evict", 32'(gnt_evict), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;

        // Back-to-back fill of the empty table.
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fill_ready", 32'(req_ready), 32'h1);
            chk("fill_alloc_en", 32'(alloc_en), 32'h1);
            chk("fill_v_alloc", 32'(v_alloc), 32'h1 << i);
            tick();
            chk("fill_gnt_valid", 32'(gnt_valid), 32'h1);
            chk("fill_gnt_idx", 32'(gnt_idx), 32'(i));
            chk("fill_gnt_evict", 32'(gnt_evict), 32'h0);
        end
        req_valid = 1'b0;
        #1;
        chk("fill_occupancy", 32'(occupancy), 32'h4);
        chk("fill_valid_vec", 32'(valid_vec), 32'hf);
        chk("idle_alloc_en", 32'(alloc_en), 32'h0);
        tick();
        chk("fill_gnt_drop", 32'(gnt_valid), 32'h0);

        // Evictions follow the tree order: 0 then 2.
        req_valid = 1'b1;
        #1;
        chk("ev1_v_alloc", 32'(v_alloc), 32'h1);
        tick();
        chk("ev1_gnt_idx", 32'(gnt_idx), 32'h0);
        chk("ev1_gnt_evict", 32'(gnt_evict), 32'h1);
        chk("ev1_evict_cnt", 32'(evict_cnt), 32'h1);
        #1;
        chk("ev2_v_alloc", 32'(v_alloc), 32'h4);
        tick();
        chk("ev2_gnt_valid", 32'(gnt_valid), 32'h1);
        chk("ev2_gnt_idx", 32'(gnt_idx), 32'h2);
        chk("ev2_evict_cnt", 32'(evict_cnt), 32'h2);
        req_valid = 1'b0;
        tick();

        // Locked entries are skipped; all-locked blocks the request.
        do_reset();
        chk("rst2_evict_cnt", 32'(evict_cnt), 32'h0);
        fill4();
        lock_mask = 4'b0001;
        req_valid = 1'b1;
        #1;
        chk("lock_v_alloc", 32'(v_alloc), 32'h2);
        tick();
        chk("lock_gnt_idx", 32'(gnt_idx), 32'h1);
        chk("lock_gnt_evict", 32'(gnt_evict), 32'h1);
        lock_mask = 4'b1111;
        #1;
        chk("alllock_ready", 32'(req_ready), 32'h0);
        chk("alllock_alloc_en", 32'(alloc_en), 32'h0);
        tick();
        chk("alllock_gnt1", 32'(gnt_valid), 32'h0);
        tick();
        chk("alllock_gnt2", 32'(gnt_valid), 32'h0);
        req_valid = 1'b0;
        lock_mask = '0;

        // Hit beats a same-cycle request and reorders the next victim.
        do_reset();
        fill4();
        hit_valid = 1'b1;
        hit_idx   = 2'd0;
        req_valid = 1'b1;
        #1;
        chk("hit_ready", 32'(req_ready), 32'h0);
        chk("hit_alloc_en", 32'(alloc_en), 32'h1);
        chk("hit_v_alloc", 32'(v_alloc), 32'h1);
        tick();
        chk("hit_no_gnt", 32'(gnt_valid), 32'h0);
        hit_valid = 1'b0;
        #1;
        chk("posthit_ready", 32'(req_ready), 32'h1);
        chk("posthit_v_alloc", 32'(v_alloc), 32'h4);
        tick();
        chk("posthit_gnt_idx", 32'(gnt_idx), 32'h2);
        req_valid = 1'b0;

        // Invalidate then refill the hole; then same-cycle inv and accept.
        inv_valid = 1'b1;
        inv_idx   = 2'd2;
        tick();
        inv_valid = 1'b0;
        chk("inv_occupancy", 32'(occupancy), 32'h3);
        chk("inv_valid_vec", 32'(valid_vec), 32'hb);
        req_valid = 1'b1;
        #1;
        chk("refill_v_alloc", 32'(v_alloc), 32'h4);
        tick();
        req_valid = 1'b0;
        chk("refill_gnt_idx", 32'(gnt_idx), 32'h2);
        chk("refill_gnt_evict", 32'(gnt_evict), 32'h0);
        chk("refill_occupancy", 32'(occupancy), 32'h4);
        lock_mask = 4'b1011;
        inv_valid = 1'b1;
        inv_idx   = 2'd2;
        req_valid = 1'b1;
        #1;
        chk("invacc_v_alloc", 32'(v_alloc), 32'h4);
        tick();
        inv_valid = 1'b0;
        req_valid = 1'b0;
        lock_mask = '0;
        chk("invacc_gnt_idx", 32'(gnt_idx), 32'h2);
        chk("invacc_gnt_evict", 32'(gnt_evict), 32'h1);
        chk("invacc_valid_vec", 32'(valid_vec), 32'hf);
        chk("invacc_evict_cnt", 32'(evict_cnt), 32'h2);

        // Flush clears valids but keeps the eviction count.
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(req_ready), 32'h0);
        tick();
        flush = 1'b0;
        chk("flush_valid_vec", 32'(valid_vec), 32'h0);
        chk("flush_occupancy", 32'(occupancy), 32'h0);
        chk("flush_evict_cnt", 32'(evict_cnt), 32'h2);
        req_valid = 1'b1;
        #1;
        chk("flush_state_ready", 32'(req_ready), 32'h0);
        tick();
        chk("flush_no_gnt", 32'(gnt_valid), 32'h0);
        #1;
        chk("postflush_ready", 32'(req_ready), 32'h1);
        chk("postflush_v_alloc", 32'(v_alloc), 32'h1);
        tick();
        chk("postflush_gnt_idx", 32'(gnt_idx), 32'h0);
        chk("postflush_gnt_evict", 32'(gnt_evict), 32'h0);

        // Reset during an accepting cycle drops the pending grant.
        #1;
        chk("midrst_ready", 32'(req_ready), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid_vec", 32'(valid_vec), 32'h0);
        tick();
        chk("midrst_gnt1", 32'(gnt_valid), 32'h0);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        tick();
        chk("midrst_gnt2", 32'(gnt_valid), 32'h0);
        chk("midrst_occupancy", 32'(occupancy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/plru_victim_alloc.md
Name: plru_victim_alloc

Overview:
Allocation front-end for a small fully-associative structure, paired with the tree pseudo-LRU stage.
- Accepts allocation requests and tracks per-entry valid bits.
- Picks the lowest-index free entry, or else the least-recently-used unlocked entry, using the pairwise recency matrix from the PLRU stage.
- Drives the PLRU update (alloc_en/v_alloc) for allocations and hits.
- Returns a registered grant with eviction information.

Parameters:
- WIDTH, 4, number of entries; power of two, at least 2.
- IDX_W, $clog2(WIDTH), entry index width.
- CNT_W, 16, width of the eviction counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  allocation request
- req_ready  out  1  request accepted when req_valid and req_ready are both high
- hit_valid  in  1  access to an existing entry; updates recency
- hit_idx  in  IDX_W  entry that was hit
- inv_valid  in  1  invalidate one entry
- inv_idx  in  IDX_W  entry to invalidate
- flush  in  1  invalidate all entries
- lock_mask  in  WIDTH  1 means the entry must not be chosen as victim
- vv_matrix  in  WIDTH x WIDTH  recency matrix from the PLRU stage; [i][j]=1 means entry i was used more recently than entry j; diagonal is 0
- alloc_en  out  1  PLRU update strobe
- v_alloc  out  WIDTH  one-hot entry being touched
- gnt_valid  out  1  one-cycle grant pulse
- gnt_idx  out  IDX_W  granted entry
- gnt_evict  out  1  granted entry held valid data (eviction)
- valid_vec  out  WIDTH  current valid bits
- occupancy  out  IDX_W+1  number of valid entries
- evict_cnt  out  CNT_W  saturating count of evictions

Behaviour:
- Reset values: valid_vec=0, occupancy=0, evict_cnt=0, gnt_valid=0, gnt_idx=0, gnt_evict=0. FSM resets to IDLE.
- FSM has two states, IDLE and FLUSH.
  - flush=1 in any state moves the FSM to FLUSH at the next edge and clears valid_vec at that edge.
  - FLUSH lasts exactly one cycle (longer if flush is held), then returns to IDLE.
- req_ready = IDLE and !flush and !hit_valid and candidate_exists.
  - candidate_exists = any entry free (~valid), or any entry unlocked.
- Victim selection is combinational, in the same cycle as acceptance.
  - If any entry is free: sel = lowest-index free entry; lock_mask is ignored for free entries.
  - Otherwise: sel = the unlocked entry v with vv_matrix[v][j]==0 for every unlocked j != v.
  - Ties cannot occur because the PLRU order is total. As a fallback, choose the lowest unlocked index.
- PLRU drive, combinational, at most one source per cycle:
  - hit_valid=1 (FSM in IDLE): alloc_en=1, v_alloc=onehot(hit_idx).
  - else, on accept: alloc_en=1, v_alloc=onehot(sel).
  - else: alloc_en=0, v_alloc=0.
  - Hits are ignored in FLUSH.
- Hit has priority over request: req_ready is forced low in the hit cycle. Single-cycle hit-to-request and request-to-request back-to-back are both legal, because the PLRU registers its update at the same edge.
- Grant is registered, latency 1.
  - Accept in cycle T gives gnt_valid=1 in T+1, with gnt_idx=sel and gnt_evict=valid_vec[sel] sampled in T.
  - gnt_valid is 0 in every other cycle. There is no grant backpressure.
- Valid update at the edge:
  - inv_valid clears valid[inv_idx].
  - Accept sets valid[sel].
  - Same index in the same cycle: set wins.
  - flush overrides everything.
- occupancy is registered and equals popcount of the next valid_vec.
- evict_cnt increments on an accept with an evicting victim and saturates at all-ones. It is not cleared by flush.
- Full and every entry locked: req_ready=0 and no grant is issued.
- Asserting rst_n low mid-operation clears all state immediately. A grant pending for the next cycle is dropped.

Decomposition:
- Shared package plru_pkg holds:
  - FSM state enum (ST_IDLE, ST_FLUSH)
  - onehot and popcount functions
  - default WIDTH/CNT_W constants
- One natural sub-module: plru_lru_pick, the combinational masked minimum-row search over vv_matrix and the candidate mask. It is reusable by other matrix-based selectors.
- Bench instantiates the real tree_plru so that vv_matrix is closed-loop.

Test Plan:
- Reset, then four back-to-back requests -> grants idx 0,1,2,3 at T+1 with gnt_evict=0; occupancy reaches 4; alloc_en pulses in each accept cycle.
- Continuing from full (fill order 0,1,2,3), request -> gnt_idx=0, gnt_evict=1, evict_cnt=1. Next request -> gnt_idx=2, evict_cnt=2.
- Full after fill 0,1,2,3 with lock_mask=4'b0001 -> victim idx 1. lock_mask=4'b1111 -> req_ready=0 and no gnt_valid while req_valid is held.
- hit_valid=1 with hit_idx=0 and req_valid=1 in the same cycle -> req_ready=0, v_alloc=4'b0001. Next cycle the request is accepted using the updated matrix.
- inv_valid=1, inv_idx=2 with a full table, then request -> gnt_idx=2, gnt_evict=0, occupancy returns to 4. Same-cycle inv and accept on idx 2 -> valid[2] stays 1.
- flush while full -> valid_vec=0 and occupancy=0 next cycle; req_ready=0 during FLUSH; evict_cnt unchanged; then request -> gnt_idx=0. Reset asserted in the cycle after an accept -> gnt_valid never rises.
